// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared 16:1 bit mux: registered select, one-hot grant,
// and a hold limit that forces a handover when an owner sits on the mux while others wait.
module mux16_rr_sched #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   output logic [3:0]  sel,
   output logic [15:0] gnt,
   output logic        gnt_valid,
   output logic        preempt
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   // First set bit of mask at or above base, wrapping 15->0; base is returned for an empty mask.
   function automatic logic [3:0] pick(input logic [15:0] mask, input logic [3:0] base);
      logic [3:0] idx;
      logic [3:0] res;
      res = base;
      for (int k = 15; k >= 0; k--) begin
         idx = base + 4'(k);
         if (mask[idx]) begin
            res = idx;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] gnt_q, gnt_d;
   logic        gnt_valid_q, gnt_valid_d;
   logic        preempt_q, preempt_d;

   logic [15:0] others_s;
   logic [3:0]  pick_req_s;
   logic [3:0]  pick_oth_s;
   logic        grant_s;
   logic [3:0]  win_s;

   // The owner is always sel_q, so the competitor set is the request vector minus that bit.
   assign others_s   = req & ~(16'b1 << sel_q);
   assign pick_req_s = pick(req, ptr_q);
   assign pick_oth_s = pick(others_s, ptr_q);

   // Next-state, grant selection and output decode.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      preempt_d   = 1'b0;
      grant_s     = 1'b0;
      win_s       = pick_req_s;

      case (state_q)
         ST_IDLE: begin
            if (req != 16'h0000) begin
               grant_s = 1'b1;
               win_s   = pick_req_s;
            end else begin
               gnt_d       = 16'h0000;
               gnt_valid_d = 1'b0;
            end
         end
         ST_OWN: begin
            // A release takes precedence over a hold-limit expiry on the same cycle.
            if (!req[sel_q]) begin
               if (others_s != 16'h0000) begin
                  grant_s = 1'b1;
                  win_s   = pick_oth_s;
               end else begin
                  state_d     = ST_IDLE;
                  gnt_d       = 16'h0000;
                  gnt_valid_d = 1'b0;
               end
            end else if ((others_s != 16'h0000) && (cnt_q == HOLD_LAST)) begin
               grant_s   = 1'b1;
               win_s     = pick_oth_s;
               preempt_d = 1'b1;
            end else if (cnt_q != HOLD_LAST) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_d       = 16'h0000;
            gnt_valid_d = 1'b0;
         end
      endcase

      if (grant_s) begin
         state_d     = ST_OWN;
         sel_d       = win_s;
         gnt_d       = 16'b1 << win_s;
         gnt_valid_d = 1'b1;
         cnt_d       = 8'd0;
         ptr_d       = win_s + 4'd1;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 4'd0;
         cnt_q       <= 8'd0;
         sel_q       <= 4'd0;
         gnt_q       <= 16'h0000;
         gnt_valid_q <= 1'b0;
         preempt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         preempt_q   <= preempt_d;
      end
   end

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Randomized and directed bench for mux16_rr_sched: one instance with MAX_HOLD=4 and one
// with MAX_HOLD=1, each compared every cycle against a behavioural round-robin model.
module tb_mux16_rr_sched;

   logic        clk;
   logic        rst_n;
   logic [15:0] req_a, req_b;
   logic [3:0]  sel_a, sel_b;
   logic [15:0] gnt_a, gnt_b;
   logic        gv_a, gv_b;
   logic        pre_a, pre_b;

   int errors = 0;
   int checks = 0;

   int hold_m  [2] = '{4, 1};
   int m_owner [2];
   int m_ptr   [2];
   int m_cnt   [2];
   int m_busy  [2];
   int m_pre   [2];

   mux16_rr_sched #(.MAX_HOLD(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a),
      .sel(sel_a), .gnt(gnt_a), .gnt_valid(gv_a), .preempt(pre_a)
   );

   mux16_rr_sched #(.MAX_HOLD(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b),
      .sel(sel_b), .gnt(gnt_b), .gnt_valid(gv_b), .preempt(pre_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick_m(input logic [15:0] mask, input int p);
      for (int k = 0; k < 16; k++) begin
         if (mask[(p + k) % 16]) return (p + k) % 16;
      end
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0; m_busy[i] = 0; m_pre[i] = 0;
      end
   endtask

   task automatic model_grant(input int i, input logic [15:0] mask);
      m_owner[i] = pick_m(mask, m_ptr[i]);
      m_ptr[i]   = (m_owner[i] + 1) % 16;
      m_cnt[i]   = 0;
      m_busy[i]  = 1;
   endtask

   task automatic model_step(input int i, input logic [15:0] r);
      logic [15:0] others;
      m_pre[i] = 0;
      if (m_busy[i] == 0) begin
         if (r != 16'h0000) model_grant(i, r);
      end else begin
         others = r & ~(16'd1 << m_owner[i]);
         if (!r[m_owner[i]]) begin
            if (others != 16'h0000) model_grant(i, others);
            else m_busy[i] = 0;
         end else if (others != 16'h0000 && m_cnt[i] == hold_m[i] - 1) begin
            model_grant(i, others);
            m_pre[i] = 1;
         end else if (m_cnt[i] < hold_m[i] - 1) begin
            m_cnt[i]++;
         end
      end
   endtask

   task automatic check_all();
      check_eq("a_sel",  32'(sel_a), 32'(m_owner[0]));
      check_eq("a_gnt",  32'(gnt_a), m_busy[0] != 0 ? (32'd1 << m_owner[0]) : 32'd0);
      check_eq("a_gv",   32'(gv_a),  32'(m_busy[0]));
      check_eq("a_pre",  32'(pre_a), 32'(m_pre[0]));
      check_eq("b_sel",  32'(sel_b), 32'(m_owner[1]));
      check_eq("b_gnt",  32'(gnt_b), m_busy[1] != 0 ? (32'd1 << m_owner[1]) : 32'd0);
      check_eq("b_gv",   32'(gv_b),  32'(m_busy[1]));
      check_eq("b_pre",  32'(pre_b), 32'(m_pre[1]));
   endtask

   task automatic step(input logic [15:0] ra, input logic [15:0] rb);
      req_a = ra;
      req_b = rb;
      @(posedge clk);
      model_step(0, ra);
      model_step(1, rb);
      #1;
      check_all();
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst_n = 1'b0;
      req_a = 16'h0000;
      req_b = 16'h0000;
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset.
      for (int n = 0; n < 10; n++) step(16'h0000, 16'h0000);

      // Wrap-around from ptr=0 and back.
      step(16'h8001, 16'h0000);
      check_eq("wrap_first", 32'(sel_a), 32'd0);
      step(16'h8000, 16'h0000);
      check_eq("wrap_15", 32'(gnt_a), 32'h8000);
      step(16'h0001, 16'h0000);
      check_eq("wrap_back", 32'(sel_a), 32'd0);
      step(16'h0000, 16'h0000);

      // Two steady competitors under the hold limit.
      for (int n = 0; n < 13; n++) step(16'h0030, 16'h0000);
      step(16'h0000, 16'h0000);

      // Lone requester never preempted, then released.
      for (int n = 0; n < 20; n++) step(16'h0080, 16'h0000);
      check_eq("lone_sel", 32'(sel_a), 32'd7);
      step(16'h0000, 16'h0000);
      check_eq("lone_rel", 32'(gv_a), 32'd0);
      step(16'h0000, 16'h0000);

      // Release coinciding with hold-limit expiry.
      step(16'h0004, 16'h0000);
      for (int n = 0; n < 3; n++) step(16'h0204, 16'h0000);
      step(16'h0200, 16'h0000);
      check_eq("rel_vs_pre_sel", 32'(sel_a), 32'd9);
      check_eq("rel_vs_pre_pre", 32'(pre_a), 32'd0);
      step(16'h0000, 16'h0000);

      // All requesters with MAX_HOLD=1, then asynchronous reset mid-sequence.
      for (int n = 0; n < 18; n++) step(16'h0000, 16'hFFFF);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      step(16'h0000, 16'hFFFF);
      check_eq("post_rst_sel", 32'(sel_b), 32'd0);
      for (int n = 0; n < 5; n++) step(16'h0000, 16'hFFFF);

      // Randomized traffic with occasional steady phases and idle gaps.
      ra = 16'h0000;
      rb = 16'h0000;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) ra = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 3) == 0) rb = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 15) == 0) ra = 16'h0000;
         if ($urandom_range(0, 15) == 0) rb = 16'h0000;
         step(ra, rb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
